// File: rtl/regbank_arbiter.sv
// regbank_arbiter: shares one write / two read register bank between two
// requesters (0 = core datapath, 1 = debug/loader). At most one bank access
// per cycle, round-robin on ties, optional locked sequences guarded by a
// timeout watchdog, and a registered per-requester read-valid strobe.
module regbank_arbiter #(
  parameter int DATA_W   = 8,
  parameter int IDX_W    = 3,
  parameter int LOCK_MAX = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_i,
  input  logic [1:0]          we_i,
  input  logic [1:0]          lock_i,
  input  logic [2*IDX_W-1:0]  ra_i,
  input  logic [2*IDX_W-1:0]  rb_i,
  input  logic [2*IDX_W-1:0]  rd_i,
  input  logic [2*DATA_W-1:0] wd_i,
  output logic [1:0]          gnt_o,
  output logic [1:0]          rvalid_o,
  output logic [DATA_W-1:0]   rdata_a_o,
  output logic [DATA_W-1:0]   rdata_b_o,
  output logic                lock_err_o,
  output logic                bk_rw_o,
  output logic [IDX_W-1:0]    bk_ri_a_o,
  output logic [IDX_W-1:0]    bk_ri_b_o,
  output logic [IDX_W-1:0]    bk_ri_d_o,
  output logic [DATA_W-1:0]   bk_d_o,
  input  logic [DATA_W-1:0]   bk_a_i,
  input  logic [DATA_W-1:0]   bk_b_i
);

  localparam int CNT_W = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOCK0 = 2'd1,
    S_LOCK1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;     // index granted most recently
  logic [1:0]       rvalid_q, rvalid_d;
  logic             lock_err_q;
  logic             timeout;

  logic             granted;
  logic             gnt_idx;
  logic             g_lock;
  logic             g_we;

  assign granted = |gnt_o;
  assign gnt_idx = gnt_o[1];
  assign g_lock  = granted & lock_i[gnt_idx];
  assign g_we    = granted & we_i[gnt_idx];

  // Output logic: pick the requester served this cycle (combinational grant).
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    gnt_o = 2'b00;
    if (rst_n) begin
      case (state_q)
        S_IDLE: begin
          case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            // Tie: serve the requester that did not win last time.
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
          endcase
        end
        S_LOCK0: gnt_o = {1'b0, req_i[0]};
        S_LOCK1: gnt_o = {req_i[1], 1'b0};
        default: gnt_o = 2'b00;
      endcase
    end
  end

  // Bank controls: route the granted requester's slice, zeros when idle.
  always_comb begin
    bk_rw_o   = g_we;
    bk_ri_a_o = '0;
    bk_ri_b_o = '0;
    bk_ri_d_o = '0;
    bk_d_o    = '0;
    if (granted) begin
      bk_ri_a_o = gnt_idx ? ra_i[2*IDX_W-1:IDX_W]   : ra_i[IDX_W-1:0];
      bk_ri_b_o = gnt_idx ? rb_i[2*IDX_W-1:IDX_W]   : rb_i[IDX_W-1:0];
      bk_ri_d_o = gnt_idx ? rd_i[2*IDX_W-1:IDX_W]   : rd_i[IDX_W-1:0];
      bk_d_o    = gnt_idx ? wd_i[2*DATA_W-1:DATA_W] : wd_i[DATA_W-1:0];
    end
  end

  // Next-state logic: lock entry/release and the lock watchdog.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timeout = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (g_lock) begin
          state_d = gnt_idx ? S_LOCK1 : S_LOCK0;
          cnt_d   = '0;
        end
      end
      S_LOCK0, S_LOCK1: begin
        cnt_d = cnt_q + 1'b1;
        if (granted && !g_lock) begin
          // Owner's final access of the sequence releases the lock.
          state_d = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          // Held too long: force release; a grant this cycle still happens.
          state_d = S_IDLE;
          timeout = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Round-robin pointer and read-valid pipeline inputs.
  always_comb begin
    last_d   = granted ? gnt_idx : last_q;
    rvalid_d = gnt_o & {2{~g_we}};
  end

  // State register: FSM, watchdog counter, round-robin pointer, strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      last_q     <= 1'b1;
      rvalid_q   <= 2'b00;
      lock_err_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      rvalid_q   <= rvalid_d;
      lock_err_q <= timeout;
    end
  end

  assign rvalid_o   = rvalid_q;
  assign lock_err_o = lock_err_q;
  assign rdata_a_o  = bk_a_i;
  assign rdata_b_o  = bk_b_i;

  // Grant is one-hot or zero and never given to an idle requester.
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(gnt_o));
  a_gnt_req: assert property (@(posedge clk) disable iff (!rst_n)
    (gnt_o & ~req_i) == 2'b00);

endmodule

// File: tb/tb_regbank_arbiter.sv
// Bench for regbank_arbiter: directed vectors push expected grants, read
// responses and lock errors into queues; a monitor pops and compares each
// time the DUT presents one. A behavioural register bank sits on bk_*.
module tb_regbank_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req, we, lock;
  logic [5:0]  ra, rb, rd;
  logic [15:0] wd;
  logic [1:0]  gnt, rvalid;
  logic [7:0]  rdata_a, rdata_b, bk_d, bk_a, bk_b;
  logic        lock_err, bk_rw;
  logic [2:0]  bk_ri_a, bk_ri_b, bk_ri_d;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [15:0] cyc;
    logic [1:0]  g;
    logic        rw;
    logic [2:0]  a;
    logic [2:0]  b;
    logic [2:0]  d;
    logic [7:0]  wd;
  } gnt_t;

  typedef struct packed {
    logic [15:0] cyc;
    logic [1:0]  v;
    logic [7:0]  a;
    logic [7:0]  b;
  } rd_t;

  gnt_t q_gnt[$];
  rd_t  q_rd[$];
  int   q_err[$];

  // Bank contents (model-side) and the bench's own expectation copy.
  logic [7:0] mem     [8] = '{8'h5A, 8'h3C, 8'h11, 8'h77, 8'h44, 8'h22, 8'h96, 8'hE1};
  logic [7:0] ref_mem [8] = '{8'h5A, 8'h3C, 8'h11, 8'h77, 8'h44, 8'h22, 8'h96, 8'hE1};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register bank: write on the edge ending the write cycle, read 1 cycle later.
  always @(posedge clk) begin
    if (bk_rw) mem[bk_ri_d] <= bk_d;
    bk_a <= mem[bk_ri_a];
    bk_b <= mem[bk_ri_b];
  end

  regbank_arbiter #(.DATA_W(8), .IDX_W(3), .LOCK_MAX(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .we_i       (we),
    .lock_i     (lock),
    .ra_i       (ra),
    .rb_i       (rb),
    .rd_i       (rd),
    .wd_i       (wd),
    .gnt_o      (gnt),
    .rvalid_o   (rvalid),
    .rdata_a_o  (rdata_a),
    .rdata_b_o  (rdata_b),
    .lock_err_o (lock_err),
    .bk_rw_o    (bk_rw),
    .bk_ri_a_o  (bk_ri_a),
    .bk_ri_b_o  (bk_ri_b),
    .bk_ri_d_o  (bk_ri_d),
    .bk_d_o     (bk_d),
    .bk_a_i     (bk_a),
    .bk_b_i     (bk_b)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of requests; eg is the hand-computed grant for it.
  task automatic apply(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                       input logic [5:0] a, input logic [5:0] b, input logic [5:0] d,
                       input logic [15:0] wdat, input logic [1:0] eg, input bit rsp = 1'b1);
    gnt_t e;
    rd_t  x;
    logic i;
    req = r; we = w; lock = l; ra = a; rb = b; rd = d; wd = wdat;
    if (eg != 2'b00) begin
      i    = eg[1];
      e.cyc = cyc[15:0];
      e.g   = eg;
      e.rw  = w[i];
      e.a   = i ? a[5:3] : a[2:0];
      e.b   = i ? b[5:3] : b[2:0];
      e.d   = i ? d[5:3] : d[2:0];
      e.wd  = i ? wdat[15:8] : wdat[7:0];
      q_gnt.push_back(e);
      if (e.rw) begin
        ref_mem[e.d] = e.wd;
      end else if (rsp) begin
        x = '{16'(cyc + 1), eg, ref_mem[e.a], ref_mem[e.b]};
        q_rd.push_back(x);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apply(2'b00, 2'b00, 2'b00, 6'd0, 6'd0, 6'd0, 16'd0, 2'b00);
  endtask

  // Monitor: compare every presented grant / read response / lock error.
  always @(negedge clk) begin
    gnt_t ag;
    rd_t  ar;
    ag = '{cyc[15:0], gnt, bk_rw, bk_ri_a, bk_ri_b, bk_ri_d, bk_d};
    if (gnt != 2'b00) begin
      if (q_gnt.size() == 0) check("gnt_unexpected", 64'(ag), 64'(0));
      else                   check("gnt", 64'(ag), 64'(q_gnt.pop_front()));
    end else begin
      check("idle_bus", 64'({bk_rw, bk_ri_a, bk_ri_b, bk_ri_d, bk_d}), 64'(0));
    end
    ar = '{cyc[15:0], rvalid, rdata_a, rdata_b};
    if (rvalid != 2'b00) begin
      if (q_rd.size() == 0) check("rvalid_unexpected", 64'(ar), 64'(0));
      else                  check("rdata", 64'(ar), 64'(q_rd.pop_front()));
    end
    if (lock_err) begin
      if (q_err.size() == 0) check("lock_err_unexpected", 64'(cyc), 64'(-1));
      else                   check("lock_err", 64'(cyc), 64'(q_err.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req = '0; we = '0; lock = '0; ra = '0; rb = '0; rd = '0; wd = '0;

    // Reset state
    repeat (2) begin
      @(negedge clk);
      check("rst_rvalid", 64'(rvalid), 64'(0));
      check("rst_lock_err", 64'(lock_err), 64'(0));
      check("rst_gnt_rw", 64'({gnt, bk_rw}), 64'(0));
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: single read by requester 0, r2/r5
    apply(2'b01, 2'b00, 2'b00, {3'd0, 3'd2}, {3'd0, 3'd5}, 6'd0, 16'd0, 2'b01);
    idle();
    // single read by requester 1 (pointer now favours requester 0 on ties)
    apply(2'b10, 2'b00, 2'b00, {3'd6, 3'd0}, {3'd7, 3'd0}, 6'd0, 16'd0, 2'b10);
    idle();

    // 2: both request for 4 cycles -> 01,10,01,10
    apply(2'b11, 2'b00, 2'b00, {3'd7, 3'd1}, {3'd0, 3'd6}, 6'd0, 16'd0, 2'b01);
    apply(2'b11, 2'b00, 2'b00, {3'd7, 3'd1}, {3'd0, 3'd6}, 6'd0, 16'd0, 2'b10);
    apply(2'b11, 2'b00, 2'b00, {3'd7, 3'd1}, {3'd0, 3'd6}, 6'd0, 16'd0, 2'b01);
    apply(2'b11, 2'b00, 2'b00, {3'd7, 3'd1}, {3'd0, 3'd6}, 6'd0, 16'd0, 2'b10);
    idle();

    // 3: requester 1 writes r3=AB, requester 0 reads r3 right after
    apply(2'b10, 2'b10, 2'b00, 6'd0, 6'd0, {3'd3, 3'd0}, {8'hAB, 8'h00}, 2'b10);
    apply(2'b01, 2'b00, 2'b00, {3'd0, 3'd3}, {3'd0, 3'd2}, 6'd0, 16'd0, 2'b01);
    idle();

    // 4: locked read-modify-write of r4 by requester 0, requester 1 held off
    apply(2'b01, 2'b00, 2'b01, {3'd0, 3'd4}, {3'd0, 3'd4}, 6'd0, 16'd0, 2'b01);
    apply(2'b10, 2'b00, 2'b00, {3'd4, 3'd0}, {3'd3, 3'd0}, 6'd0, 16'd0, 2'b00);
    apply(2'b11, 2'b01, 2'b00, {3'd4, 3'd0}, {3'd3, 3'd0}, {3'd0, 3'd4}, {8'h00, 8'h45}, 2'b01);
    apply(2'b10, 2'b00, 2'b00, {3'd4, 3'd0}, {3'd3, 3'd0}, 6'd0, 16'd0, 2'b10);
    idle();

    // 5: lock held by an idle owner for LOCK_MAX cycles -> timeout
    apply(2'b01, 2'b00, 2'b01, {3'd0, 3'd0}, {3'd0, 3'd1}, 6'd0, 16'd0, 2'b01);
    repeat (16)
      apply(2'b10, 2'b00, 2'b00, {3'd5, 3'd0}, {3'd2, 3'd0}, 6'd0, 16'd0, 2'b00);
    q_err.push_back(cyc);
    apply(2'b10, 2'b00, 2'b00, {3'd5, 3'd0}, {3'd2, 3'd0}, 6'd0, 16'd0, 2'b10);
    idle();
    idle();

    // 6: reset the cycle after a read grant; result discarded, pointer reset
    apply(2'b01, 2'b00, 2'b00, {3'd0, 3'd3}, {3'd0, 3'd5}, 6'd0, 16'd0, 2'b01, 1'b0);
    rst_n = 1'b0;
    req = 2'b11; we = 2'b00; lock = 2'b00;
    ra = {3'd1, 3'd2}; rb = {3'd3, 3'd4};
    repeat (2) begin
      @(negedge clk);
      check("rst6_rvalid", 64'(rvalid), 64'(0));
      check("rst6_lock_err", 64'(lock_err), 64'(0));
      check("rst6_gnt_rw", 64'({gnt, bk_rw}), 64'(0));
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    apply(2'b11, 2'b00, 2'b00, {3'd1, 3'd2}, {3'd3, 3'd4}, 6'd0, 16'd0, 2'b01);
    apply(2'b10, 2'b00, 2'b00, {3'd1, 3'd2}, {3'd3, 3'd4}, 6'd0, 16'd0, 2'b10);
    idle();
    idle();

    // Every expected response must have been observed
    check("gnt_missing", 64'(q_gnt.size()), 64'(0));
    check("rdata_missing", 64'(q_rd.size()), 64'(0));
    check("lock_err_missing", 64'(q_err.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
